// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
//   in_data    : word to serialize (WIDTH bits), sampled only on accept
//   in_valid   : upstream has a word
//   in_ready   : serializer can accept this cycle
//   x_out      : serial bit stream (idles at IDLE_BIT)
//   bit_strobe : one-cycle pulse in the first cycle of each new bit
//   busy       : high while a word is being shifted
//   frame_done : one-cycle pulse in the final clock of a word's last bit
// The master modport is the upstream word source and downstream observer.
// The slave modport is the serializer itself.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x_out;
  logic             bit_strobe;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  x_out,
    input  bit_strobe,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output x_out,
    output bit_strobe,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence-detector FSMs.
// Words arrive on a valid/ready handshake and are shifted out one bit every
// DIV clocks on x_out. Consecutive words are gapless when upstream offers the
// next word in the final cycle of the current one.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : bit_serializer_if.slave (in_data/in_valid/in_ready handshake,
//           x_out, bit_strobe, busy, frame_done outputs)
// All outputs except in_ready are registered. in_ready is decoded from the
// state and counters so a new word can be taken in the last cycle of a word.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   DIV       = 1,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  bit_serializer_if.slave     bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = $clog2(DIV + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             x_out_q, x_out_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             last_cycle;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  // The final clock of a word is the only SHIFT cycle where a new word may be
  // taken; accepting here is what makes back-to-back words gapless.
  assign last_cycle   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT) &&
                        (div_cnt_q == LAST_DIV);
  assign bus.in_ready = (state_q == IDLE) || last_cycle;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.x_out      = x_out_q;
  assign bus.bit_strobe = bit_strobe_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

  // Next-state logic. x_out_q always mirrors the output end of sreg_q while
  // shifting, so the next bit is taken from the already-shifted word.
  // busy and frame_done are precomputed from the next state so they can be
  // registered and still line up with the cycle they describe.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    x_out_d      = x_out_q;
    bit_strobe_d = 1'b0;
    shifted      = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

    if (accept) begin
      state_d      = SHIFT;
      sreg_d       = bus.in_data;
      x_out_d      = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
      bit_cnt_d    = '0;
      div_cnt_d    = '0;
      bit_strobe_d = 1'b1;
    end else if (state_q == SHIFT) begin
      if (div_cnt_q == LAST_DIV) begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = IDLE;
          sreg_d    = '0;
          x_out_d   = IDLE_BIT;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else begin
          sreg_d       = shifted;
          x_out_d      = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
          bit_cnt_d    = bit_cnt_q + BCW'(1);
          div_cnt_d    = '0;
          bit_strobe_d = 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + DCW'(1);
      end
    end

    busy_d       = (state_d == SHIFT);
    frame_done_d = (state_d == SHIFT) && (bit_cnt_d == LAST_BIT) &&
                   (div_cnt_d == LAST_DIV);
  end

  // State and output registers. Reset drops any partial word immediately,
  // so no frame_done is ever produced for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      x_out_q      <= IDLE_BIT;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      x_out_q      <= x_out_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
